// File: rtl/arkhe_hbm_port_arbiter.sv
// In-order tag FIFO: holds the requester index of each issued read beat until its data returns.
// Latency: a pushed entry is at pop_dat on the next cycle; full/empty are registered counts.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop ignored when empty.
module arkhe_hbm_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop_rdy && !empty;
    assign do_push = push_vld && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// HBM pseudo-channel arbiter: round-robin burst grants, beat address generation, in-order read return.
// Latency: grant 1 cycle after req_valid in IDLE; beats pass through combinationally; rsp 1 cycle after hbm_rvalid.
// Backpressure: owner stalls on hbm_ready or a full tag FIFO (reads only); responses have no backpressure.
module arkhe_hbm_port_arbiter #(
    parameter int N_REQ     = 4,
    parameter int LEN_W     = 4,
    parameter int TAG_DEPTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ-1:0]     req_we,
    input  logic [N_REQ*32-1:0]  req_addr,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    input  logic [N_REQ*256-1:0] req_wdata,
    output logic                 hbm_valid,
    input  logic                 hbm_ready,
    output logic [31:0]          hbm_addr,
    output logic                 hbm_we,
    output logic [255:0]         hbm_data_out,
    input  logic                 hbm_rvalid,
    input  logic [255:0]         hbm_data_in,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [255:0]         rsp_data,
    output logic [N_REQ-1:0]     grant,
    output logic                 err_timeout,
    output logic                 err_orphan
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    typedef struct packed {
        logic             we;
        logic [31:0]      base;
        logic [LEN_W-1:0] last_idx;
        logic [PTR_W-1:0] owner;
    } burst_t;

    logic [0:0]       state;
    burst_t           burst_q;
    logic [LEN_W-1:0] beat_idx;
    logic [TO_W-1:0]  to_cnt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_next;

    logic             pick_vld;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] cand_idx;
    int               cand;

    logic             in_burst;
    logic             xfer;
    logic             last_beat;
    logic             timeout_hit;

    logic             tag_full;
    logic             tag_empty;
    logic             tag_pop;
    logic [PTR_W-1:0] tag_out;

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!pick_vld && req_valid[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    assign in_burst     = (state == BURST);
    assign hbm_valid    = in_burst && req_valid[burst_q.owner] && (burst_q.we || !tag_full);
    assign xfer         = hbm_valid && hbm_ready;
    assign req_ready    = xfer ? (N_REQ'(1) << burst_q.owner) : '0;
    assign hbm_we       = in_burst && burst_q.we;
    assign hbm_addr     = in_burst ? (burst_q.base + (32'(beat_idx) << 5)) : '0;
    assign hbm_data_out = in_burst ? req_wdata[int'(burst_q.owner)*256 +: 256] : '0;
    assign last_beat    = xfer && (beat_idx == burst_q.last_idx);
    assign timeout_hit  = in_burst && !xfer && (to_cnt == TO_W'(TIMEOUT - 1));
    assign rr_next      = (burst_q.owner == PTR_W'(N_REQ - 1)) ? '0 : burst_q.owner + PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            burst_q     <= '0;
            beat_idx    <= '0;
            to_cnt      <= '0;
            rr_ptr      <= '0;
            grant       <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state            <= BURST;
                        grant            <= N_REQ'(1) << pick_idx;
                        burst_q.we       <= req_we[pick_idx];
                        burst_q.base     <= req_addr[int'(pick_idx)*32 +: 32];
                        burst_q.last_idx <= req_len[int'(pick_idx)*LEN_W +: LEN_W];
                        burst_q.owner    <= pick_idx;
                        beat_idx         <= '0;
                        to_cnt           <= '0;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beat_idx <= beat_idx + LEN_W'(1);
                        to_cnt   <= '0;
                        if (last_beat) begin
                            state  <= IDLE;
                            grant  <= '0;
                            rr_ptr <= rr_next;
                        end
                    end else if (timeout_hit) begin
                        // Abort keeps already-pushed read tags so their data still routes home.
                        state       <= IDLE;
                        grant       <= '0;
                        rr_ptr      <= rr_next;
                        to_cnt      <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tag_pop = hbm_rvalid && !tag_empty;

    arkhe_hbm_tag_fifo #(
        .W     (PTR_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (xfer && !burst_q.we),
        .push_dat (burst_q.owner),
        .pop_rdy  (tag_pop),
        .pop_dat  (tag_out),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= '0;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp_valid <= tag_pop ? (N_REQ'(1) << tag_out) : '0;
            if (tag_pop) begin
                rsp_data <= hbm_data_in;
            end
            if (hbm_rvalid && tag_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_arkhe_hbm_port_arbiter.sv
// Directed bench for arkhe_hbm_port_arbiter with a 4-deep tag FIFO and a 16-cycle timeout.
module tb_arkhe_hbm_port_arbiter;
    localparam int N_REQ = 4;
    localparam int LEN_W = 4;

    logic                     clk;
    logic                     rst;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ-1:0]         req_we;
    logic [N_REQ*32-1:0]      req_addr;
    logic [N_REQ*LEN_W-1:0]   req_len;
    logic [N_REQ*256-1:0]     req_wdata;
    logic                     hbm_valid;
    logic                     hbm_ready;
    logic [31:0]              hbm_addr;
    logic                     hbm_we;
    logic [255:0]             hbm_data_out;
    logic                     hbm_rvalid;
    logic [255:0]             hbm_data_in;
    logic [N_REQ-1:0]         rsp_valid;
    logic [255:0]             rsp_data;
    logic [N_REQ-1:0]         grant;
    logic                     err_timeout;
    logic                     err_orphan;

    int vectors;
    int miscompares;

    arkhe_hbm_port_arbiter #(
        .N_REQ     (N_REQ),
        .LEN_W     (LEN_W),
        .TAG_DEPTH (4),
        .TIMEOUT   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .req_wdata    (req_wdata),
        .hbm_valid    (hbm_valid),
        .hbm_ready    (hbm_ready),
        .hbm_addr     (hbm_addr),
        .hbm_we       (hbm_we),
        .hbm_data_out (hbm_data_out),
        .hbm_rvalid   (hbm_rvalid),
        .hbm_data_in  (hbm_data_in),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .grant        (grant),
        .err_timeout  (err_timeout),
        .err_orphan   (err_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [255:0] wd0;
    logic [255:0] d0;
    logic [255:0] d1;
    logic [255:0] d2;
    logic [3:0]   rr_seq [8];
    int           beats;
    int           pulses;

    initial begin
        vectors     = 0;
        miscompares = 0;
        wd0 = {8{32'hDEADBEEF}};
        d0  = {8{32'h0000_00D0}};
        d1  = {8{32'h1111_00D1}};
        d2  = {8{32'h2222_00D2}};
        rr_seq[0] = 4'b0000; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0000; rr_seq[3] = 4'b0100;
        rr_seq[4] = 4'b0000; rr_seq[5] = 4'b1000; rr_seq[6] = 4'b0000; rr_seq[7] = 4'b0001;

        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
        hbm_ready = 1'b0; hbm_rvalid = 1'b0; hbm_data_in = '0;
        #3;
        chk("rst_grant", 256'(grant), 256'(4'b0000));
        chk("rst_hbm_valid", 256'(hbm_valid), 256'(1'b0));
        chk("rst_hbm_addr", 256'(hbm_addr), 256'(32'h0));
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(4'b0000));
        chk("rst_errs", 256'({err_timeout, err_orphan}), 256'(2'b00));

        // single 4-beat write from requester 0
        tick();
        rst = 1'b0;
        req_we[0] = 1'b1; req_addr[0 +: 32] = 32'h1000; req_len[0 +: 4] = 4'd3;
        req_wdata[0 +: 256] = wd0; req_valid = 4'b0001; hbm_ready = 1'b1;
        #1;
        chk("t1_grant_latency", 256'(grant), 256'(4'b0000));
        tick();
        chk("t1_grant", 256'(grant), 256'(4'b0001));
        chk("t1_hbm_we", 256'(hbm_we), 256'(1'b1));
        chk("t1_wdata", hbm_data_out, wd0);
        for (int b = 0; b < 4; b++) begin
            chk("t1_addr", 256'(hbm_addr), 256'(32'h1000 + 32'(b) * 32'h20));
            chk("t1_ready", 256'(req_ready), 256'(4'b0001));
            tick();
        end
        chk("t1_idle_grant", 256'(grant), 256'(4'b0000));
        chk("t1_idle_valid", 256'(hbm_valid), 256'(1'b0));
        req_valid = 4'b0011; req_we = 4'b0011; req_len = '0;
        tick();
        chk("t1_rr_ptr1", 256'(grant), 256'(4'b0010));
        tick();
        chk("t1_gap", 256'(grant), 256'(4'b0000));
        tick();
        chk("t1_wrap_to0", 256'(grant), 256'(4'b0001));

        // round robin with all four requesting single beats
        req_valid = 4'b1111; req_we = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t2_rr_grant", 256'(grant), 256'(rr_seq[k]));
        end
        tick();
        req_valid = 4'b0000;

        // read routing: req2 two beats, then req1 one beat
        req_we = 4'b0000; req_len[8 +: 4] = 4'd1; req_addr[64 +: 32] = 32'h2000;
        req_valid = 4'b0100;
        tick();
        chk("t3_grant2", 256'(grant), 256'(4'b0100));
        chk("t3_read_we", 256'(hbm_we), 256'(1'b0));
        chk("t3_addr0", 256'(hbm_addr), 256'(32'h2000));
        tick();
        chk("t3_addr1", 256'(hbm_addr), 256'(32'h2020));
        tick();
        req_valid = 4'b0010; req_len[4 +: 4] = 4'd0; req_addr[32 +: 32] = 32'h3000;
        tick();
        chk("t3_grant1", 256'(grant), 256'(4'b0010));
        chk("t3_addr_r1", 256'(hbm_addr), 256'(32'h3000));
        tick();
        req_valid = 4'b0000;
        hbm_rvalid = 1'b1; hbm_data_in = d0;
        #1;
        chk("t3_rsp_not_early", 256'(rsp_valid), 256'(4'b0000));
        tick();
        chk("t3_rsp0_vld", 256'(rsp_valid), 256'(4'b0100));
        chk("t3_rsp0_dat", rsp_data, d0);
        hbm_data_in = d1;
        tick();
        chk("t3_rsp1_vld", 256'(rsp_valid), 256'(4'b0100));
        chk("t3_rsp1_dat", rsp_data, d1);
        hbm_data_in = d2;
        tick();
        chk("t3_rsp2_vld", 256'(rsp_valid), 256'(4'b0010));
        chk("t3_rsp2_dat", rsp_data, d2);
        hbm_rvalid = 1'b0;
        tick();
        chk("t3_rsp_idle", 256'(rsp_valid), 256'(4'b0000));

        // tag FIFO full: 8-beat read into a 4-deep FIFO
        req_len[0 +: 4] = 4'd7; req_addr[0 +: 32] = 32'h4000; req_valid = 4'b0001;
        tick();
        chk("t4_grant", 256'(grant), 256'(4'b0001));
        beats = 0;
        for (int i = 0; i < 6; i++) begin
            if (hbm_valid && hbm_ready) beats++;
            tick();
        end
        chk("t4_beats_until_full", 256'(beats), 256'(4));
        chk("t4_stalled", 256'(hbm_valid), 256'(1'b0));
        chk("t4_stall_addr", 256'(hbm_addr), 256'(32'h4080));
        hbm_rvalid = 1'b1;
        tick();
        hbm_rvalid = 1'b0;
        chk("t4_rsp_pop", 256'(rsp_valid), 256'(4'b0001));
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            if (hbm_valid && hbm_ready) beats++;
            tick();
        end
        chk("t4_one_more_beat", 256'(beats), 256'(1));
        chk("t4_stalled_again", 256'(hbm_valid), 256'(1'b0));
        hbm_rvalid = 1'b1;
        beats = 0; pulses = 0;
        for (int i = 0; i < 7; i++) begin
            if (hbm_valid && hbm_ready) beats++;
            tick();
            if (rsp_valid == 4'b0001) pulses++;
            if (i == 3) req_valid = 4'b0000;
        end
        hbm_rvalid = 1'b0;
        chk("t4_drain_beats", 256'(beats), 256'(3));
        chk("t4_drain_rsp", 256'(pulses), 256'(7));
        chk("t4_done_grant", 256'(grant), 256'(4'b0000));
        chk("t4_no_orphan", 256'(err_orphan), 256'(1'b0));

        // timeout: req1 stalls mid-burst, req2 waiting
        req_we = 4'b0110; req_len[4 +: 4] = 4'd3; req_len[8 +: 4] = 4'd0;
        req_addr[32 +: 32] = 32'h5000; req_valid = 4'b0010;
        tick();
        chk("t5_grant1", 256'(grant), 256'(4'b0010));
        tick();
        req_valid = 4'b0100;
        #1;
        chk("t5_owner_stall", 256'(hbm_valid), 256'(1'b0));
        chk("t5_stall_ready", 256'(req_ready), 256'(4'b0000));
        for (int i = 0; i < 15; i++) tick();
        chk("t5_held_grant", 256'(grant), 256'(4'b0010));
        chk("t5_no_err_yet", 256'(err_timeout), 256'(1'b0));
        tick();
        chk("t5_abort_grant", 256'(grant), 256'(4'b0000));
        chk("t5_err_timeout", 256'(err_timeout), 256'(1'b1));
        tick();
        chk("t5_next_grant", 256'(grant), 256'(4'b0100));
        tick();
        req_valid = 4'b0000;

        // orphan read data, then reset in the middle of a burst
        hbm_rvalid = 1'b1;
        tick();
        hbm_rvalid = 1'b0;
        chk("t6_err_orphan", 256'(err_orphan), 256'(1'b1));
        chk("t6_orphan_rsp", 256'(rsp_valid), 256'(4'b0000));
        req_we[3] = 1'b1; req_len[12 +: 4] = 4'd5; req_addr[96 +: 32] = 32'h6000;
        req_valid = 4'b1000;
        tick();
        chk("t6_grant3", 256'(grant), 256'(4'b1000));
        tick();
        chk("t6_addr_beat1", 256'(hbm_addr), 256'(32'h6020));
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_grant", 256'(grant), 256'(4'b0000));
        chk("t6_rst_hbm_valid", 256'(hbm_valid), 256'(1'b0));
        chk("t6_rst_req_ready", 256'(req_ready), 256'(4'b0000));
        chk("t6_rst_addr", 256'(hbm_addr), 256'(32'h0));
        chk("t6_rst_we", 256'(hbm_we), 256'(1'b0));
        chk("t6_rst_wdata", hbm_data_out, 256'(0));
        chk("t6_rst_errs", 256'({err_timeout, err_orphan}), 256'(2'b00));
        req_valid = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_post_rst_grant", 256'(grant), 256'(4'b0000));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
